s_box: RTL and testbench

//   AES SubBytes byte substitution, registered: maps one 8-bit input byte to its

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/s_box_lut.sv | 39 +++
 rtl/s_box.sv | 49 ++++
 tb/tb_s_box.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared types and constant tables for the aes/ datapath.
//   aes_byte_t : one AES state byte.
//   SBOX       : FIPS-197 forward substitution table, indexed by input byte.
//   INV_SBOX   : FIPS-197 inverse substitution table. It is declared only
//                when AES_INV_SBOX_EN is defined, so forward-only builds
//                carry no inverse table at all.
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  // Rows of sixteen entries: the row is the high nibble of the index and
  // the column is the low nibble.
  localparam aes_byte_t SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_INV_SBOX_EN
  localparam aes_byte_t INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/s_box_lut.sv
// ---------------------------------------------------------------------------
// s_box_lut
//   Purely combinational AES byte substitution lookup.
//   Ports:
//     i_byte : byte to substitute
//     i_inv  : 1 selects the inverse table (present only with AES_INV_SBOX_EN)
//     o_sub  : substituted byte
//   Macro AES_INV_SBOX_EN adds i_inv and the inverse table; without it the
//   lookup is the forward table only.
// ---------------------------------------------------------------------------
module s_box_lut
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef AES_INV_SBOX_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_sub
);

  aes_byte_t w_fwd;

  // The table is a constant, so this index synthesises to a 256-entry ROM
  // made of plain logic with no storage.
  assign w_fwd = SBOX[i_byte];

`ifdef AES_INV_SBOX_EN
  aes_byte_t w_inv;

  assign w_inv = INV_SBOX[i_byte];

  // Both tables are looked up in parallel and the result is picked last,
  // keeping the inv select off the long path through the ROM.
  assign o_sub = i_inv ? w_inv : w_fwd;
`else
  assign o_sub = w_fwd;
`endif

endmodule

// File: rtl/s_box.sv
// ---------------------------------------------------------------------------
// s_box
//   Registered AES SubBytes primitive: one byte in, its S-box value out one
//   clock later. Instantiate 4 or 16 copies for word or state substitution.
//   Ports:
//     clk     : rising-edge clock
//     rst_n   : asynchronous active-low reset, clears subByte to 00
//     inByte  : byte to substitute, sampled every rising edge
//     inv     : 1 = inverse S-box (present only with AES_INV_SBOX_EN)
//     subByte : registered substitution result
//   Macro AES_INV_SBOX_EN adds the inv port and the inverse table.
// ---------------------------------------------------------------------------
module s_box
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inByte,
`ifdef AES_INV_SBOX_EN
  input  logic       inv,
`endif
  output logic [7:0] subByte
);

  aes_byte_t w_lutOut;
  aes_byte_t r_subByte;

  s_box_lut u_lut (
    .i_byte (inByte),
`ifdef AES_INV_SBOX_EN
    .i_inv  (inv),
`endif
    .o_sub  (w_lutOut)
  );

  // The output comes straight from a flop, so no lookup glitches are
  // visible downstream. Reset clears it without waiting for a clock, and a
  // byte sampled on an edge that coincides with reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_subByte <= '0;
    end else begin
      r_subByte <= w_lutOut;
    end
  end

  assign subByte = r_subByte;

endmodule

// File: tb/tb_s_box.sv
// ---------------------------------------------------------------------------
// tb_s_box
//   Self-checking bench for s_box. The reference tables are derived from
//   the AES definition itself: multiplicative inverse in GF(2^8) modulo
//   x^8+x^4+x^3+x+1 followed by the affine transform with constant 63.
//   The inverse table is the inverse permutation of that forward table.
//   Define AES_INV_SBOX_EN to also exercise the inverse path.
// ---------------------------------------------------------------------------
module tb_s_box;

  logic       clk;
  logic       rst_n;
  logic [7:0] inByte;
  logic [7:0] subByte;
`ifdef AES_INV_SBOX_EN
  logic       inv;
`endif

  int compareCount;
  int mismatchCount;

  logic [7:0] refSbox [256];
  logic [7:0] refInv  [256];

  s_box dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inByte  (inByte),
`ifdef AES_INV_SBOX_EN
    .inv     (inv),
`endif
    .subByte (subByte)
  );

  // 10 time-unit clock; rising edges at 5, 15, ... and falling at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse of a in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gfMul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] aesSub(input logic [7:0] x);
    logic [7:0] b;
    b = gfInv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  // Builds the reference tables before any stimulus is applied.
  task automatic buildModel();
    for (int x = 0; x < 256; x++) refSbox[x] = aesSub(8'(x));
    for (int x = 0; x < 256; x++) refInv[refSbox[x]] = 8'(x);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    inByte = 8'h00;
`ifdef AES_INV_SBOX_EN
    inv    = 1'b0;
`endif
    #1;
    compareCount++;
    if (subByte !== 8'h00) begin
      mismatchCount++;
      $display("[TB] FAIL reset_initial: got %h expected 00", subByte);
    end
    // Clock edges with reset held and random inputs must not load anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compareCount++;
      if (subByte !== 8'h00) begin
        mismatchCount++;
        $display("[TB] FAIL reset_hold[%0d]: got %h expected 00", i, subByte);
      end
      inByte = 8'($urandom_range(0, 255));
    end
    // Release, load one value, then assert reset between edges.
    @(negedge clk);
    rst_n  = 1'b1;
    inByte = 8'h53;
    @(negedge clk);
    compareCount++;
    if (subByte !== 8'hed) begin
      mismatchCount++;
      $display("[TB] FAIL reset_release_first: got %h expected ed", subByte);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compareCount++;
    if (subByte !== 8'h00) begin
      mismatchCount++;
      $display("[TB] FAIL reset_async_assert: got %h expected 00", subByte);
    end
    @(negedge clk);
    inByte = 8'h9a;
    @(negedge clk);
    compareCount++;
    if (subByte !== 8'h00) begin
      mismatchCount++;
      $display("[TB] FAIL reset_async_hold: got %h expected 00", subByte);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] stim [3];
    logic [7:0] want [3];
    stim = '{8'h9a, 8'h9f, 8'h06};
    want = '{8'hb8, 8'hdb, 8'h6f};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inByte = stim[i];
      @(negedge clk);
      compareCount++;
      if (subByte !== want[i]) begin
        mismatchCount++;
        $display("[TB] FAIL directed_%h: got %h expected %h", stim[i], subByte, want[i]);
      end
    end
  endtask

  // Each boundary byte must not appear before the rising edge that samples it.
  task automatic test_boundaries();
    logic [7:0] stim [3];
    logic [7:0] want [3];
    logic [7:0] prevWant;
    stim = '{8'h00, 8'hff, 8'h53};
    want = '{8'h63, 8'h16, 8'hed};
    @(negedge clk);
    inByte   = 8'h9f;
    @(negedge clk);
    prevWant = 8'hdb;
    for (int i = 0; i < 3; i++) begin
      inByte = stim[i];
      #2;
      compareCount++;
      if (subByte !== prevWant) begin
        mismatchCount++;
        $display("[TB] FAIL boundary_early_%h: got %h expected %h", stim[i], subByte, prevWant);
      end
      @(negedge clk);
      compareCount++;
      if (subByte !== want[i]) begin
        mismatchCount++;
        $display("[TB] FAIL boundary_%h: got %h expected %h", stim[i], subByte, want[i]);
      end
      prevWant = want[i];
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] last;
    last = 8'h00;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) begin
        compareCount++;
        if (subByte !== refSbox[last]) begin
          mismatchCount++;
          $display("[TB] FAIL stream_%h: got %h expected %h", last, subByte, refSbox[last]);
        end
      end
      if (i < 256) begin
        last   = 8'(i);
        inByte = last;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] last;
    last = 8'h00;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        compareCount++;
        if (subByte !== refSbox[last]) begin
          mismatchCount++;
          $display("[TB] FAIL random_%h: got %h expected %h", last, subByte, refSbox[last]);
        end
      end
      last   = 8'($urandom_range(0, 255));
      inByte = last;
    end
  endtask

`ifdef AES_INV_SBOX_EN
  task automatic test_inverse();
    logic [7:0] y;
    logic       lastInv;
    @(negedge clk);
    inv    = 1'b1;
    inByte = 8'h63;
    @(negedge clk);
    compareCount++;
    if (subByte !== 8'h00) begin
      mismatchCount++;
      $display("[TB] FAIL inv_63: got %h expected 00", subByte);
    end
    inByte = 8'hb8;
    @(negedge clk);
    compareCount++;
    if (subByte !== 8'h9a) begin
      mismatchCount++;
      $display("[TB] FAIL inv_b8: got %h expected 9a", subByte);
    end
    // inv toggles every cycle with the data held.
    inByte  = 8'h9a;
    lastInv = 1'b0;
    inv     = lastInv;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      compareCount++;
      if (subByte !== (lastInv ? 8'h37 : 8'hb8)) begin
        mismatchCount++;
        $display("[TB] FAIL inv_toggle[%0d]: got %h expected %h", i, subByte, lastInv ? 8'h37 : 8'hb8);
      end
      lastInv = ~lastInv;
      inv     = lastInv;
    end
    // Forward then inverse through the DUT must return the original byte.
    for (int x = 0; x < 256; x++) begin
      inv    = 1'b0;
      inByte = 8'(x);
      @(negedge clk);
      y = subByte;
      compareCount++;
      if (y !== refSbox[x]) begin
        mismatchCount++;
        $display("[TB] FAIL trip_fwd_%h: got %h expected %h", 8'(x), y, refSbox[x]);
      end
      inv    = 1'b1;
      inByte = y;
      @(negedge clk);
      compareCount++;
      if (subByte !== 8'(x) || refInv[refSbox[x]] !== 8'(x)) begin
        mismatchCount++;
        $display("[TB] FAIL trip_inv_%h: got %h expected %h", 8'(x), subByte, 8'(x));
      end
    end
    inv = 1'b0;
  endtask
`endif

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n         = 1'b0;
    inByte        = 8'h00;
`ifdef AES_INV_SBOX_EN
    inv           = 1'b0;
`endif
    buildModel();
    test_reset();
    test_directed();
    test_boundaries();
    test_back_to_back();
    test_random();
`ifdef AES_INV_SBOX_EN
    test_inverse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
